// File: rtl/p2s_pkg.sv
// Shared types and defaults for the parallel-to-serial transmitter.
package p2s_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} p2s_state_t;
  localparam int P2S_DEF_WIDTH = 8;
  localparam int P2S_MIN_GAP   = 1;
endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry word buffer; a write and a read on the same edge leaves it full with the new word.
module p2s_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd) full_d = 1'b0;
    if (wr) begin
      data_d = wdata;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rdata = data_q;
  assign full  = full_q;
endmodule

// File: rtl/parallel2serial.sv
// Serialises handshaked parallel words LSB first with a start pulse and a forced inter-frame gap.
// Optional frame counter output enabled by defining P2S_FRAME_CNT_EN.
module parallel2serial
  import p2s_pkg::*;
#(
  parameter int WIDTH      = P2S_DEF_WIDTH,
  parameter int GAP_CYCLES = P2S_MIN_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_start,
  output logic             d,
  output logic             busy,
  output logic             frame_done
`ifdef P2S_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  p2s_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             start_q, start_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             fdone_q, fdone_d;
  logic             load;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  assign din_ready = !hold_full;

  p2s_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (din_valid && din_ready),
    .rd    (load),
    .wdata (din),
    .rdata (hold_data),
    .full  (hold_full)
  );

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    shreg_d = shreg_q;
    load    = 1'b0;
    start_d = 1'b0;
    dout_d  = 1'b0;
    fdone_d = 1'b0;
    busy_d  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          shreg_d = hold_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        start_d = (cnt_q == '0);
        dout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          gcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        fdone_d = (gcnt_q == '0);
        gcnt_d  = gcnt_q + GW'(1);
        if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
          if (hold_full) begin
            load    = 1'b1;
            shreg_d = hold_data;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      shreg_q <= '0;
      start_q <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      shreg_q <= shreg_d;
      start_q <= start_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  assign serial_start = start_q;
  assign d            = dout_q;
  assign busy         = busy_q;
  assign frame_done   = fdone_q;

`ifdef P2S_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb fcnt_d = fcnt_q + 16'(fdone_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_parallel2serial.sv
// Directed bench for parallel2serial: timing of a single frame, loopback words, back-to-back, stall, reset.
module tb_parallel2serial;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, serial_start, d, busy, frame_done;
`ifdef P2S_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  parallel2serial #(.WIDTH(8), .GAP_CYCLES(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .serial_start (serial_start),
    .d            (d),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef P2S_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: rebuild words from serial_start + 8 bits.
  logic [7:0] mw;
  logic [3:0] midx = 4'd0;
  int         mstart = 0;
  int         fd_cnt = 0;
  logic [7:0] wq[$];
  int         sq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      midx = 4'd0;
    end else begin
      if (frame_done) fd_cnt = fd_cnt + 1;
      if (serial_start) begin
        mw     = 8'h00;
        mw[0]  = d;
        midx   = 4'd1;
        mstart = cyc;
      end else if (midx != 4'd0) begin
        mw[midx[2:0]] = d;
        midx = midx + 4'd1;
        if (midx == 4'd8) begin
          wq.push_back(mw);
          sq.push_back(mstart);
          midx = 4'd0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] w);
    logic rdy;
    int   t;
    din       = w;
    din_valid = 1'b1;
    t         = 0;
    do begin
      rdy = din_ready;
      step();
      t++;
    end while (!rdy && t < 200);
    chk("send_accepted", 32'(rdy), 32'd1);
    din_valid = 1'b0;
  endtask

  task automatic get(output logic [7:0] w, output int sc);
    int t;
    t = 0;
    while (wq.size() == 0 && t < 100) begin
      step();
      t++;
    end
    chk("word_available", 32'(wq.size() != 0), 32'd1);
    if (wq.size() != 0) begin
      w  = wq.pop_front();
      sc = sq.pop_front();
    end else begin
      w  = 8'hxx;
      sc = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rw, exp_w;
    logic [7:0] words[4];
    int         sc1, sc2, fd0, t;

    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0;
    step(2);
    chk("rst_serial_start", 32'(serial_start), 32'd0);
    chk("rst_d",            32'(d),            32'd0);
    chk("rst_busy",         32'(busy),         32'd0);
    chk("rst_frame_done",   32'(frame_done),   32'd0);
    chk("rst_din_ready",    32'(din_ready),    32'd1);
    rst_n = 1'b1;
    step(2);

    // Single word 0xA5, cycle-accurate: start at T+2, frame_done at T+10.
    exp_w = 8'hA5;
    din = exp_w; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("single_ready_full", 32'(din_ready), 32'd0);
    step();
    chk("single_t1_start", 32'(serial_start), 32'd0);
    chk("single_t1_ready", 32'(din_ready), 32'd1);
    step();
    chk("single_start", 32'(serial_start), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("single_bit", 32'(d), 32'(exp_w[i]));
      chk("single_busy", 32'(busy), 32'd1);
      if (i > 0) chk("single_no_start", 32'(serial_start), 32'd0);
      step();
    end
    chk("single_frame_done", 32'(frame_done), 32'd1);
    chk("single_gap_d",      32'(d),          32'd0);
    chk("single_gap_busy",   32'(busy),       32'd1);
    step();
    chk("single_done_pulse", 32'(frame_done), 32'd0);
    chk("single_idle_busy",  32'(busy),       32'd0);
    get(rw, sc1);
    chk("single_word", 32'(rw), 32'hA5);

    // Loopback words, one frame_done each.
    words[0] = 8'hA5; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'h3C;
    fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      send(words[i]);
      get(rw, sc1);
      chk("loop_word", 32'(rw), 32'(words[i]));
    end
    step(12);
    chk("loop_frame_done_cnt", 32'(fd_cnt - fd0), 32'd4);

    // Back-to-back 0x3C, 0xC3: period of 9 cycles.
    send(8'h3C);
    chk("b2b_ready_full1", 32'(din_ready), 32'd0);
    send(8'hC3);
    chk("b2b_ready_full2", 32'(din_ready), 32'd0);
    t = 0;
    while (!din_ready && t < 30) begin
      step();
      t++;
    end
    chk("b2b_ready_rise", 32'(din_ready), 32'd1);
    step();
    chk("b2b_start_after_drain", 32'(serial_start), 32'd1);
    get(rw, sc1);
    chk("b2b_word1", 32'(rw), 32'h3C);
    get(rw, sc2);
    chk("b2b_word2", 32'(rw), 32'hC3);
    chk("b2b_period", 32'(sc2 - sc1), 32'd9);

    // Stall: three words with the hold full; no loss or duplication.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    get(rw, sc1); chk("stall_w0", 32'(rw), 32'h11);
    get(rw, sc1); chk("stall_w1", 32'(rw), 32'h22);
    get(rw, sc1); chk("stall_w2", 32'(rw), 32'h33);
    step(30);
    chk("stall_no_extra", 32'(wq.size()), 32'd0);

    // Reset during bit 4 of 0xF0.
    send(8'hF0);
    t = 0;
    while (!serial_start && t < 20) begin
      step();
      t++;
    end
    chk("rstmid_started", 32'(serial_start), 32'd1);
    step(4);
    chk("rstmid_bit4", 32'(d), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_start", 32'(serial_start), 32'd0);
    chk("rstmid_d",     32'(d),            32'd0);
    chk("rstmid_busy",  32'(busy),         32'd0);
    chk("rstmid_done",  32'(frame_done),   32'd0);
    chk("rstmid_ready", 32'(din_ready),    32'd1);
    step(2);
    rst_n = 1'b1;
    step();
    chk("rstmid_no_word", 32'(wq.size()), 32'd0);
    send(8'h81);
    get(rw, sc1);
    chk("rstmid_after_word", 32'(rw), 32'h81);
    step(12);
    chk("rstmid_clean_tail", 32'(wq.size()), 32'd0);

`ifdef P2S_FRAME_CNT_EN
    rst_n = 1'b0;
    step();
    chk("fcnt_reset", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    send(8'h01); send(8'h02); send(8'h03);
    step(30);
    chk("fcnt_three", 32'(frame_cnt), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
